// File: rtl/accelerator_dnc_pkg.sv
// Shared types and constants for the DNC accelerator read path.
// No logic: FSM state encoding, read-mode count and the fixed-point unit.
// Imported by the read-weighting datapath and its MAC helper.
package accelerator_dnc_pkg;

  // Sequencer states of the read-weighting engine
  typedef enum logic [2:0] {
    STARTER = 3'd0,
    PI      = 3'd1,
    VECTOR  = 3'd2,
    MAC     = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  // Backward, content and forward read modes
  localparam int READ_MODES = 3;

  // Fixed-point 1.0 for the default 32 fractional bits
  localparam int          DEFAULT_FRACTION_SIZE = 32;
  localparam logic [63:0] ONE = 64'd1 << DEFAULT_FRACTION_SIZE;

endpackage

// File: rtl/accelerator_read_weighting_mac.sv
// One multiply-accumulate step: sum = acc + ((weight * operand) >>> FRACTION_SIZE).
// Purely combinational (zero latency); the accumulator register lives in the parent.
// No flow control. ACCELERATOR_READ_WEIGHTING_SATURATION_EN selects saturating vs wrapping add.
module accelerator_read_weighting_mac #(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] acc,
  input  logic [DATA_SIZE-1:0] weight,
  input  logic [DATA_SIZE-1:0] operand,
  output logic [DATA_SIZE-1:0] sum
);

  // Full-precision product: both operands sign-extended to double width
  logic signed [2*DATA_SIZE-1:0] product;
  // Product rescaled back to the fixed-point grid and truncated to the word width
  logic        [DATA_SIZE-1:0]   term;

`ifdef ACCELERATOR_READ_WEIGHTING_SATURATION_EN
  localparam logic [DATA_SIZE-1:0] MOST_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};
  // One guard bit: the sum overflowed when the guard and sign bits disagree
  logic [DATA_SIZE:0] wide;
`endif

  // Multiply, arithmetic shift, then accumulate (saturating or modulo)
  always_comb begin
    product = $signed({{DATA_SIZE{weight[DATA_SIZE-1]}}, weight})
            * $signed({{DATA_SIZE{operand[DATA_SIZE-1]}}, operand});
    term    = DATA_SIZE'(product >>> FRACTION_SIZE);
`ifdef ACCELERATOR_READ_WEIGHTING_SATURATION_EN
    wide = {acc[DATA_SIZE-1], acc} + {term[DATA_SIZE-1], term};
    if (wide[DATA_SIZE] != wide[DATA_SIZE-1]) begin
      sum = wide[DATA_SIZE] ? MOST_NEG : MOST_POS;
    end else begin
      sum = wide[DATA_SIZE-1:0];
    end
`else
    sum = acc + term;
`endif
  end

endmodule

// File: rtl/accelerator_read_weighting.sv
// DNC read weighting w(i;j) = pi(i;0)*b(i;j) + pi(i;1)*c(i;j) + pi(i;2)*f(i;j), head-major order.
// Latency: VECTOR_IN_ENABLE accepted in cycle t gives W_OUT_ENABLE in cycle t+4; one output per >=5 cycles.
// Backpressure: enable/request pulses; the FSM waits indefinitely. Macro: ACCELERATOR_READ_WEIGHTING_SATURATION_EN.
module accelerator_read_weighting
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic                 PI_IN_ENABLE,
  output logic                 PI_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] PI_IN,
  input  logic                 VECTOR_IN_ENABLE,
  output logic                 VECTOR_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] B_IN,
  input  logic [DATA_SIZE-1:0] C_IN,
  input  logic [DATA_SIZE-1:0] F_IN,
  output logic                 W_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] W_OUT
);

  localparam logic [CONTROL_SIZE-1:0] CTRL_ONE  = CONTROL_SIZE'(1);
  localparam logic [1:0]              LAST_MODE = 2'(READ_MODES - 1);

  state_t state;

  // Sizes captured at START so upstream may change the size inputs mid-run
  logic [CONTROL_SIZE-1:0] size_r;
  logic [CONTROL_SIZE-1:0] size_n;
  // Head index i and element index j
  logic [CONTROL_SIZE-1:0] head_idx;
  logic [CONTROL_SIZE-1:0] elem_idx;
  // Mode index p while loading weights, m while multiplying
  logic [1:0]              load_mode;
  logic [1:0]              mac_mode;

  logic [DATA_SIZE-1:0] pi_b;
  logic [DATA_SIZE-1:0] pi_c;
  logic [DATA_SIZE-1:0] pi_f;
  logic [DATA_SIZE-1:0] b_reg;
  logic [DATA_SIZE-1:0] c_reg;
  logic [DATA_SIZE-1:0] f_reg;
  logic [DATA_SIZE-1:0] acc;

  logic [DATA_SIZE-1:0] mac_weight;
  logic [DATA_SIZE-1:0] mac_operand;
  logic [DATA_SIZE-1:0] mac_sum;

  logic more_elems;
  logic more_heads;

  // Route the read-mode weight and its matching element into the shared multiplier
  always_comb begin
    mac_weight  = pi_f;
    mac_operand = f_reg;
    case (mac_mode)
      2'd0: begin
        mac_weight  = pi_b;
        mac_operand = b_reg;
      end
      2'd1: begin
        mac_weight  = pi_c;
        mac_operand = c_reg;
      end
      default: begin
        mac_weight  = pi_f;
        mac_operand = f_reg;
      end
    endcase
  end

  // Position tests; written as idx+1 < size so a size of zero never underflows
  always_comb begin
    more_elems = (elem_idx + CTRL_ONE) < size_n;
    more_heads = (head_idx + CTRL_ONE) < size_r;
  end

  accelerator_read_weighting_mac #(
    .DATA_SIZE     (DATA_SIZE),
    .FRACTION_SIZE (FRACTION_SIZE)
  ) u_mac (
    .acc     (acc),
    .weight  (mac_weight),
    .operand (mac_operand),
    .sum     (mac_sum)
  );

  // Sequencer with registered pulse outputs. The request/READY pulse for the element
  // after the current one is decided on the last MAC edge so that it lands in the same
  // cycle as W_OUT_ENABLE; the OUTPUT cycle then only advances the indices.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state             <= STARTER;
      READY             <= 1'b0;
      PI_OUT_ENABLE     <= 1'b0;
      VECTOR_OUT_ENABLE <= 1'b0;
      W_OUT_ENABLE      <= 1'b0;
      W_OUT             <= '0;
      size_r            <= '0;
      size_n            <= '0;
      head_idx          <= '0;
      elem_idx          <= '0;
      load_mode         <= '0;
      mac_mode          <= '0;
      pi_b              <= '0;
      pi_c              <= '0;
      pi_f              <= '0;
      b_reg             <= '0;
      c_reg             <= '0;
      f_reg             <= '0;
      acc               <= '0;
    end else begin
      READY             <= 1'b0;
      PI_OUT_ENABLE     <= 1'b0;
      VECTOR_OUT_ENABLE <= 1'b0;
      W_OUT_ENABLE      <= 1'b0;
      case (state)
        STARTER: begin
          if (START) begin
            head_idx  <= '0;
            elem_idx  <= '0;
            load_mode <= '0;
            size_r    <= CONTROL_SIZE'(SIZE_R_IN);
            size_n    <= CONTROL_SIZE'(SIZE_N_IN);
            if ((SIZE_R_IN == '0) || (SIZE_N_IN == '0)) begin
              READY <= 1'b1;
            end else begin
              state <= PI;
            end
          end
        end

        PI: begin
          if (PI_IN_ENABLE) begin
            case (load_mode)
              2'd0:    pi_b <= PI_IN;
              2'd1:    pi_c <= PI_IN;
              default: pi_f <= PI_IN;
            endcase
            if (load_mode == LAST_MODE) begin
              load_mode <= '0;
              state     <= VECTOR;
            end else begin
              load_mode     <= load_mode + 2'd1;
              PI_OUT_ENABLE <= 1'b1;
            end
          end
        end

        VECTOR: begin
          if (VECTOR_IN_ENABLE) begin
            b_reg    <= B_IN;
            c_reg    <= C_IN;
            f_reg    <= F_IN;
            acc      <= '0;
            mac_mode <= '0;
            state    <= MAC;
          end
        end

        MAC: begin
          acc <= mac_sum;
          if (mac_mode == LAST_MODE) begin
            mac_mode     <= '0;
            W_OUT        <= mac_sum;
            W_OUT_ENABLE <= 1'b1;
            state        <= OUTPUT;
            if (more_elems) begin
              VECTOR_OUT_ENABLE <= 1'b1;
            end else if (more_heads) begin
              PI_OUT_ENABLE <= 1'b1;
            end else begin
              READY <= 1'b1;
            end
          end else begin
            mac_mode <= mac_mode + 2'd1;
          end
        end

        OUTPUT: begin
          if (more_elems) begin
            elem_idx <= elem_idx + CTRL_ONE;
            state    <= VECTOR;
          end else if (more_heads) begin
            head_idx  <= head_idx + CTRL_ONE;
            elem_idx  <= '0;
            load_mode <= '0;
            state     <= PI;
          end else begin
            state <= STARTER;
          end
        end

        default: state <= STARTER;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_read_weighting.sv
// Self-checking bench for accelerator_read_weighting: table rows, hand sequences and random runs.
// Expected outputs come from constants or a plain-arithmetic model of the weighting formula.
// Honours ACCELERATOR_READ_WEIGHTING_SATURATION_EN for the overflow expectations.
`timescale 1ns/1ps
module tb_accelerator_read_weighting;
  import accelerator_dnc_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        READY;
  logic [63:0] SIZE_R_IN = '0;
  logic [63:0] SIZE_N_IN = '0;
  logic        PI_IN_ENABLE = 1'b0;
  logic        PI_OUT_ENABLE;
  logic [63:0] PI_IN = '0;
  logic        VECTOR_IN_ENABLE = 1'b0;
  logic        VECTOR_OUT_ENABLE;
  logic [63:0] B_IN = '0;
  logic [63:0] C_IN = '0;
  logic [63:0] F_IN = '0;
  logic        W_OUT_ENABLE;
  logic [63:0] W_OUT;

  always #5 CLK = ~CLK;

  accelerator_read_weighting #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION_SIZE(32)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_R_IN(SIZE_R_IN), .SIZE_N_IN(SIZE_N_IN),
    .PI_IN_ENABLE(PI_IN_ENABLE), .PI_OUT_ENABLE(PI_OUT_ENABLE), .PI_IN(PI_IN),
    .VECTOR_IN_ENABLE(VECTOR_IN_ENABLE), .VECTOR_OUT_ENABLE(VECTOR_OUT_ENABLE),
    .B_IN(B_IN), .C_IN(C_IN), .F_IN(F_IN),
    .W_OUT_ENABLE(W_OUT_ENABLE), .W_OUT(W_OUT)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Job stimulus: pi per head (3 each), b/c/f per element in head-major order
  logic [63:0] jp[$];
  logic [63:0] jb[$];
  logic [63:0] jc[$];
  logic [63:0] jf[$];
  // Observations
  logic [63:0] got_q[$];
  int          got_cyc_q[$];
  int          acc_cyc_q[$];
  int          n_pireq = 0;
  int          n_vecreq = 0;
  int          n_ready = 0;
  int          n_ready_last = 0;

  always @(negedge CLK) begin
    if (W_OUT_ENABLE) begin
      got_q.push_back(W_OUT);
      got_cyc_q.push_back(cyc);
      if (READY) n_ready_last++;
    end
    if (PI_OUT_ENABLE) n_pireq++;
    if (VECTOR_OUT_ENABLE) n_vecreq++;
    if (READY) n_ready++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // w = sum_k (pi_k * x_k) >>> 32, accumulated term by term in wide arithmetic
  function automatic logic [63:0] model_w(input logic [63:0] p0, input logic [63:0] p1,
                                          input logic [63:0] p2, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] f);
    logic signed [127:0] acc;
    logic signed [127:0] a;
    logic signed [127:0] x;
    logic signed [127:0] prod;
    logic signed [63:0]  tr;
    logic signed [63:0]  lo;
    logic [63:0]         pw[3];
    logic [63:0]         xs[3];
    logic signed [127:0] m_pos;
    logic signed [127:0] m_neg;
    m_pos = 128'sh0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF;
    m_neg = -m_pos - 128'sd1;
    pw[0] = p0; pw[1] = p1; pw[2] = p2;
    xs[0] = b;  xs[1] = c;  xs[2] = f;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      a    = $signed(pw[k]);
      x    = $signed(xs[k]);
      prod = (a * x) >>> 32;
      tr   = prod[63:0];
      acc  = acc + tr;
`ifdef ACCELERATOR_READ_WEIGHTING_SATURATION_EN
      if (acc > m_pos) acc = m_pos;
      if (acc < m_neg) acc = m_neg;
`else
      lo  = acc[63:0];
      acc = lo;
`endif
    end
    return acc[63:0];
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_cyc_q.delete();
    acc_cyc_q.delete();
    n_pireq = 0; n_vecreq = 0; n_ready = 0; n_ready_last = 0;
  endtask

  task automatic send_pi(input logic [63:0] v, input int d);
    repeat (d) @(negedge CLK);
    @(negedge CLK); PI_IN_ENABLE = 1'b1; PI_IN = v;
    @(negedge CLK); PI_IN_ENABLE = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] b, input logic [63:0] c, input logic [63:0] f, input int d);
    repeat (d) @(negedge CLK);
    @(negedge CLK); VECTOR_IN_ENABLE = 1'b1; B_IN = b; C_IN = c; F_IN = f;
    acc_cyc_q.push_back(cyc);
    @(negedge CLK); VECTOR_IN_ENABLE = 1'b0;
  endtask

  // which: 0 = PI_OUT_ENABLE, 1 = VECTOR_OUT_ENABLE, 2 = READY
  task automatic wait_sig(input int which, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ((which == 0 && PI_OUT_ENABLE) || (which == 1 && VECTOR_OUT_ENABLE) || (which == 2 && READY)) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: pulse not seen within 400 cycles (got 0, expected 1)", name);
    end
  endtask

  task automatic run_job(input string tag, input int r, input int n, input int dmin, input int dmax, input bit stray);
    logic [63:0] e;
    int          idx;
    clear_mon();
    @(negedge CLK); SIZE_R_IN = 64'(r); SIZE_N_IN = 64'(n); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    if (r == 0 || n == 0) begin
      check({tag, "_ready"}, 64'(READY), 64'd1);
      repeat (4) @(negedge CLK);
      check({tag, "_outs"}, 64'(got_q.size()), 64'd0);
      check({tag, "_reqs"}, 64'(n_pireq + n_vecreq), 64'd0);
      check({tag, "_nready"}, 64'(n_ready), 64'd1);
      return;
    end
    if (stray) begin
      VECTOR_IN_ENABLE = 1'b1; B_IN = 64'hDEAD_0000_0000; C_IN = 64'hBEEF_0000_0000; F_IN = 64'h1234_0000_0000;
      @(negedge CLK); VECTOR_IN_ENABLE = 1'b0;
    end
    for (int i = 0; i < r; i++) begin
      for (int p = 0; p < 3; p++) begin
        if (i > 0 || p > 0) wait_sig(0, {tag, "_pireq"});
        send_pi(jp[i*3+p], $urandom_range(dmax, dmin));
      end
      for (int j = 0; j < n; j++) begin
        if (j > 0) wait_sig(1, {tag, "_vecreq"});
        send_vec(jb[i*n+j], jc[i*n+j], jf[i*n+j], $urandom_range(dmax, dmin));
        if (stray && i == 0 && j == 0) begin
          START = 1'b1; SIZE_R_IN = '0; SIZE_N_IN = '0;
          @(negedge CLK); START = 1'b0;
        end
      end
    end
    wait_sig(2, {tag, "_ready"});
    check({tag, "_ready_with_out"}, 64'(W_OUT_ENABLE), 64'd1);
    @(negedge CLK);
    check({tag, "_count"}, 64'(got_q.size()), 64'(r*n));
    for (int k = 0; k < r*n; k++) begin
      idx = (k / n) * 3;
      e = model_w(jp[idx], jp[idx+1], jp[idx+2], jb[k], jc[k], jf[k]);
      if (k < got_q.size()) begin
        check($sformatf("%s_w%0d", tag, k), got_q[k], e);
        check($sformatf("%s_lat%0d", tag, k), 64'(got_cyc_q[k] - acc_cyc_q[k]), 64'd4);
      end
    end
    check({tag, "_npireq"}, 64'(n_pireq), 64'(3*r - 1));
    check({tag, "_nvecreq"}, 64'(n_vecreq), 64'(r*(n-1)));
    check({tag, "_nready"}, 64'(n_ready), 64'd1);
    check({tag, "_ready_last"}, 64'(n_ready_last), 64'd1);
  endtask

  typedef struct {
    logic [63:0] p0, p1, p2, b, c, f, w;
  } row_t;
  row_t tbl[9];

  localparam logic [63:0] Q   = 64'h0000_0000_4000_0000;
  localparam logic [63:0] H   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] NEG = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] BIG = 64'h7FFF_0000_0000_0000;

  initial begin
    logic [63:0] t;
    int r;
    int n;
`ifdef ACCELERATOR_READ_WEIGHTING_SATURATION_EN
    logic [63:0] ovf_pos = 64'h7FFF_FFFF_FFFF_FFFF;
    logic [63:0] ovf_neg = 64'h8000_0000_0000_0000;
`else
    logic [63:0] ovf_pos = 64'h7FFD_0000_0000_0000;
    logic [63:0] ovf_neg = 64'h8003_0000_0000_0000;
`endif
    tbl[0] = '{Q, H, Q, ONE, 64'd0, ONE, H};
    tbl[1] = '{Q, H, Q, 64'd0, ONE, ONE, 64'h0000_0000_C000_0000};
    tbl[2] = '{ONE, 64'd0, 64'd0, H, 64'h55, 64'h66, H};
    tbl[3] = '{64'd0, 64'd0, ONE, 64'h77, 64'h88, Q, Q};
    tbl[4] = '{NEG, 64'd0, 64'd0, 64'h2_0000_0000, 64'd0, 64'd0, 64'hFFFF_FFFE_0000_0000};
    tbl[5] = '{64'd1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[6] = '{ONE, ONE, ONE, BIG, BIG, BIG, ovf_pos};
    tbl[7] = '{NEG, NEG, NEG, BIG, BIG, BIG, ovf_neg};
    tbl[8] = '{H, H, H, 64'h2_0000_0000, 64'h4_0000_0000, 64'hFFFF_FFFE_0000_0000, 64'h2_0000_0000};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ready", 64'(READY), 64'd0);
    check("rst_pireq", 64'(PI_OUT_ENABLE), 64'd0);
    check("rst_vecreq", 64'(VECTOR_OUT_ENABLE), 64'd0);
    check("rst_wen", 64'(W_OUT_ENABLE), 64'd0);
    check("rst_wout", W_OUT, 64'd0);
    check("rst_state", 64'(dut.state), 64'(STARTER));
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single-element table rows
    for (int k = 0; k < 9; k++) begin
      jp = '{tbl[k].p0, tbl[k].p1, tbl[k].p2};
      jb = '{tbl[k].b}; jc = '{tbl[k].c}; jf = '{tbl[k].f};
      run_job($sformatf("row%0d", k), 1, 1, 0, 2, 1'b0);
      if (got_q.size() > 0) check($sformatf("row%0d_const", k), got_q[0], tbl[k].w);
    end

    // Basic run
    jp = '{Q, H, Q};
    jb = '{ONE, 64'd0}; jc = '{64'd0, ONE}; jf = '{ONE, ONE};
    run_job("basic", 1, 2, 0, 0, 1'b0);
    if (got_q.size() == 2) begin
      check("basic_w0_const", got_q[0], 64'h0000_0000_8000_0000);
      check("basic_w1_const", got_q[1], 64'h0000_0000_C000_0000);
    end

    // Multi-head run
    jp = '{ONE, 64'd0, 64'd0, 64'd0, 64'd0, ONE};
    jb = '{H, 64'h1111_2222}; jc = '{64'h3333, 64'h4444}; jf = '{64'h5555_0000, Q};
    run_job("multi", 2, 1, 0, 3, 1'b0);
    if (got_q.size() == 2) begin
      check("multi_w0_const", got_q[0], H);
      check("multi_w1_const", got_q[1], Q);
    end

    // Zero sizes
    run_job("zeron", 1, 0, 0, 0, 1'b0);
    run_job("zeror", 0, 3, 0, 0, 1'b0);

    // Stray inputs: results must match the basic run
    jp = '{Q, H, Q};
    jb = '{ONE, 64'd0}; jc = '{64'd0, ONE}; jf = '{ONE, ONE};
    run_job("stray", 1, 2, 0, 1, 1'b1);
    if (got_q.size() == 2) check("stray_w1_const", got_q[1], 64'h0000_0000_C000_0000);

    // Reset in the middle of MAC
    clear_mon();
    @(negedge CLK); SIZE_R_IN = 64'd1; SIZE_N_IN = 64'd1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    send_pi(ONE, 0); wait_sig(0, "rstrun_pireq");
    send_pi(ONE, 0); wait_sig(0, "rstrun_pireq");
    send_pi(ONE, 0);
    send_vec(ONE, ONE, ONE, 0);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    check("midrst_ready", 64'(READY), 64'd0);
    check("midrst_pireq", 64'(PI_OUT_ENABLE), 64'd0);
    check("midrst_vecreq", 64'(VECTOR_OUT_ENABLE), 64'd0);
    check("midrst_wen", 64'(W_OUT_ENABLE), 64'd0);
    check("midrst_wout", W_OUT, 64'd0);
    check("midrst_state", 64'(dut.state), 64'(STARTER));
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    check("midrst_no_ready", 64'(n_ready), 64'd0);
    check("midrst_no_out", 64'(got_q.size()), 64'd0);

    // Backpressure: every answer 10 cycles after its request
    jp.delete(); jb.delete(); jc.delete(); jf.delete();
    for (int k = 0; k < 3; k++) jp.push_back(64'(k + 1) * Q);
    for (int k = 0; k < 3; k++) begin
      jb.push_back(64'(k) * ONE); jc.push_back(H); jf.push_back(64'(k + 2) * Q);
    end
    run_job("bp", 1, 3, 9, 9, 1'b0);

    // Randomized runs against the model
    for (int jn = 0; jn < 6; jn++) begin
      r = $urandom_range(3, 1);
      n = $urandom_range(4, 1);
      jp.delete(); jb.delete(); jc.delete(); jf.delete();
      for (int k = 0; k < 3*r; k++) begin
        t = {$urandom, $urandom};
        jp.push_back({{30{t[33]}}, t[33:0]});
      end
      for (int k = 0; k < r*n; k++) begin
        t = {$urandom, $urandom}; jb.push_back(t);
        t = {$urandom, $urandom}; jc.push_back({{16{t[47]}}, t[47:0]});
        t = {$urandom, $urandom}; jf.push_back(t);
      end
      run_job($sformatf("rand%0d", jn), r, n, 0, 3, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at 900us (expected to finish earlier)");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accelerator_read_weighting.md
# accelerator_read_weighting

Computes the DNC read weighting for each read head i and memory location j: w(t;i;j) = pi(t;i;0)·b(t;i;j) + pi(t;i;1)·c(t;i;j) + pi(t;i;2)·f(t;i;j). It sits directly downstream of accelerator_read_content_weighting, whose C_OUT stream supplies c. It also consumes the backward (b) and forward (f) weightings from the temporal link stage. It uses the standard enable/request streaming protocol, with one shared multiplier driven by a small FSM.

## Interface
- DATA_SIZE, 64, data word width; signed fixed point
- CONTROL_SIZE, 64, counter width
- FRACTION_SIZE, 32, fractional bits of the fixed-point format
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous and active-low
- START  in  1  one-cycle pulse that begins a run
- READY  out  1  one-cycle pulse when the run completes
- SIZE_R_IN  in  DATA_SIZE  number of read heads R
- SIZE_N_IN  in  DATA_SIZE  number of locations N
- PI_IN_ENABLE  in  1  qualifies PI_IN; for p in 0..2
- PI_OUT_ENABLE  out  1  requests the next pi element
- PI_IN  in  DATA_SIZE  read-mode weight pi(i;p)
- VECTOR_IN_ENABLE  in  1  qualifies B_IN, C_IN and F_IN together; for j in 0..N-1
- VECTOR_OUT_ENABLE  out  1  requests the next (b,c,f) element
- B_IN, C_IN, F_IN  in  DATA_SIZE  element j of head i
- W_OUT_ENABLE  out  1  qualifies W_OUT
- W_OUT  out  DATA_SIZE  w(i;j)

## Operation
- Sizes are latched at START. The element order is head-major: all N elements of head i, then head i+1.
- STARTER
  - Idle state.
  - On START: i=0, j=0, p=0.
  - If latched R=0 or N=0: pulse READY next cycle and stay in STARTER.
  - Otherwise go to PI.
- PI
  - Each PI_IN_ENABLE stores PI_IN into pi[p] and increments p.
  - After a store with p<2: pulse PI_OUT_ENABLE for one cycle.
  - After the store with p=2: go to VECTOR.
- VECTOR
  - On VECTOR_IN_ENABLE: latch B_IN, C_IN and F_IN, clear the accumulator, and go to MAC.
- MAC
  - Three cycles, with m=0,1,2 multiplying by b, c and f respectively.
  - Each cycle: acc = acc + ((pi[m]·x) >>> FRACTION_SIZE).
  - The product is 2·DATA_SIZE bits wide, arithmetic-shifted, then truncated to DATA_SIZE.
  - After three cycles go to OUTPUT.
- OUTPUT
  - Drive W_OUT=acc and W_OUT_ENABLE=1 for one cycle. Then, in the same cycle:
  - If j<N-1: j++, pulse VECTOR_OUT_ENABLE, go to VECTOR.
  - Else if i<R-1: i++, j=0, p=0, pulse PI_OUT_ENABLE, go to PI.
  - Else: pulse READY, go to STARTER.
- Inputs are ignored outside the state that consumes them:
  - PI_IN_ENABLE is honoured only in PI.
  - VECTOR_IN_ENABLE is honoured only in VECTOR.
  - START is honoured only in STARTER.

## Timing
- Reset values: READY, PI_OUT_ENABLE, VECTOR_OUT_ENABLE and W_OUT_ENABLE are 0; W_OUT is 0; FSM is in STARTER; counters and accumulator are 0.
- Reset asserted mid-run aborts the run immediately. No READY pulse follows.
- Latency: VECTOR_IN_ENABLE accepted in cycle t gives W_OUT_ENABLE high in cycle t+4.
- The request pulse is issued in the same cycle as W_OUT_ENABLE.
- Upstream may answer a request with any delay of ≥1 cycle. The FSM waits indefinitely.
- READY is high in the cycle of the last W_OUT_ENABLE. A START in the following cycle is accepted.
- Throughput: at most one output every 5 cycles.

## Configuration
- ACCELERATOR_READ_WEIGHTING_SATURATION_EN
  - Defined: each accumulate saturates to the most-positive or most-negative DATA_SIZE signed value on overflow.
  - Undefined: the accumulate wraps modulo 2^DATA_SIZE.

## Structure
- Shared package accelerator_dnc_pkg holds:
  - the FSM state enum (STARTER, PI, VECTOR, MAC, OUTPUT);
  - the constant READ_MODES=3;
  - the fixed-point ONE constant, 1<<FRACTION_SIZE.
- Sub-module accelerator_read_weighting_mac: one signed multiply, shift, and optionally saturating add. It is purely combinational, and the accumulator register stays in the parent.

## Test plan
- Basic run.
  - Stimulus: FRACTION_SIZE=32, R=1, N=2, pi=(0.25, 0.5, 0.25); b=(1,0), c=(0,1), f=(1,1).
  - Response: W_OUT=0x8000_0000 (0.5), then 0xC000_0000 (0.75); READY pulses with the second output.
- Multi-head run.
  - Stimulus: R=2, N=1, pi0=(1,0,0), pi1=(0,0,1), b=(0.5, x), f=(x, 0.25).
  - Response: outputs 0.5 then 0.25; exactly 1 PI_OUT_ENABLE pulse between heads following the 2 in-head requests.
- Zero size.
  - Stimulus: START with N=0.
  - Response: READY one cycle later; no W_OUT_ENABLE, no requests.
- Overflow.
  - Stimulus: pi=(1,1,1), b=c=f=0x7FFF_0000_0000_0000.
  - Response: with the macro defined, W_OUT=0x7FFF_FFFF_FFFF_FFFF; with it undefined, the result wraps.
- Stray inputs and reset mid-run.
  - Stimulus: VECTOR_IN_ENABLE pulsed during PI, and START pulsed during MAC; then RST low during MAC.
  - Response: the stray VECTOR_IN_ENABLE and START are ignored and the results are unchanged. After RST, all outputs are 0, the FSM is in STARTER, and no READY pulse occurs.
- Backpressure.
  - Stimulus: delay VECTOR_IN_ENABLE by 10 cycles after each request.
  - Response: correct values; each W_OUT_ENABLE comes exactly 4 cycles after its accept.
